// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Holds downstream clock domains in reset until the PLL has been locked for
//   LOCK_CYCLES cycles. It then releases rst_out[0] .. rst_out[STAGES-1] one at a
//   time, STAGE_GAP cycles apart. Lock loss or soft_rst re-asserts every reset
//   at once. Lock losses seen while fully running are counted, saturating.
//
// Ports
//   clock      in   PLL output clock
//   reset_n    in   asynchronous active-low reset
//   locked     in   PLL lock flag, asynchronous to clock
//   soft_rst   in   synchronous restart request (level or pulse)
//   rst_out    out  per-domain active-high resets, bit 0 released first
//   ready      out  high once every stage is released
//   lost_count out  saturating count of lock losses seen while running
module pll_reset_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned STAGES      = 3,
    parameter int unsigned STAGE_GAP   = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              locked,
    input  logic              soft_rst,
    output logic [STAGES-1:0] rst_out,
    output logic              ready,
    output logic [CNT_W-1:0]  lost_count
);

    localparam int unsigned MaxCnt = (LOCK_CYCLES > STAGE_GAP) ? LOCK_CYCLES : STAGE_GAP;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam int unsigned IdxW   = $clog2(STAGES + 1);

    typedef enum logic [1:0] {
        StWaitLock,
        StSettle,
        StRelease,
        StRun
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [STAGES-1:0]      rst_out_q, rst_out_d;
    logic                   ready_q, ready_d;
    logic [CNT_W-1:0]       lost_q, lost_d;

    logic locked_s;
    logic abort;

    assign locked_s = sync_q[SYNC_STAGES-1];
    assign abort    = !locked_s || soft_rst;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], locked};
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        lost_d    = lost_q;

        // Abort wins over every other transition, including the last release.
        if (state_q != StWaitLock && abort) begin
            if (state_q == StRun && !locked_s && lost_q != {CNT_W{1'b1}}) begin
                lost_d = lost_q + CNT_W'(1);
            end
            state_d   = StWaitLock;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
        end else begin
            unique case (state_q)
                StWaitLock: begin
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    cnt_d     = '0;
                    idx_d     = '0;
                    if (locked_s && !soft_rst) begin
                        state_d = StSettle;
                    end
                end
                StSettle: begin
                    if (cnt_q == CntW'(LOCK_CYCLES - 1)) begin
                        state_d = StRelease;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StRelease: begin
                    if (cnt_q == CntW'(STAGE_GAP - 1)) begin
                        for (int k = 0; k < STAGES; k++) begin
                            if (idx_q == IdxW'(k)) begin
                                rst_out_d[k] = 1'b0;
                            end
                        end
                        cnt_d = '0;
                        idx_d = idx_q + IdxW'(1);
                        if (idx_q == IdxW'(STAGES - 1)) begin
                            state_d = StRun;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StRun: begin
                    rst_out_d = '0;
                    ready_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StWaitLock;
            sync_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            lost_q    <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            lost_q    <= lost_d;
        end
    end

    assign rst_out    = rst_out_q;
    assign ready      = ready_q;
    assign lost_count = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a time-since-lock model checked every cycle,
// plus literal expectations at the interesting edges of each scenario.
module tb_pll_reset_sequencer;

    localparam int SYNC  = 2;
    localparam int LOCKC = 8;
    localparam int NST   = 3;
    localparam int GAP   = 4;
    localparam int CW    = 2;
    localparam int T_RUN = LOCKC + NST * GAP;
    localparam int LMAX  = (1 << CW) - 1;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           locked;
    logic           soft_rst;
    logic [NST-1:0] rst_out;
    logic           ready;
    logic [CW-1:0]  lost_count;

    int checks   = 0;
    int failures = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES(SYNC),
        .LOCK_CYCLES(LOCKC),
        .STAGES     (NST),
        .STAGE_GAP  (GAP),
        .CNT_W      (CW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .locked    (locked),
        .soft_rst  (soft_rst),
        .rst_out   (rst_out),
        .ready     (ready),
        .lost_count(lost_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Model: m_t counts edges since the sequence left WAIT_LOCK (-1 while waiting).
    int              m_t;
    int              m_lost;
    logic [SYNC-1:0] m_sync;

    function automatic int next_t(input int t, input logic ls, input logic sr);
        if (t < 0) return (ls && !sr) ? 0 : -1;
        if (!ls || sr) return -1;
        return (t < T_RUN) ? t + 1 : t;
    endfunction

    function automatic int next_lost(input int t, input int lost, input logic ls);
        if (t >= T_RUN && !ls && lost < LMAX) return lost + 1;
        return lost;
    endfunction

    function automatic logic [NST-1:0] exp_rst(input int t);
        logic [NST-1:0] r;
        for (int k = 0; k < NST; k++) r[k] = (t < 0) || (t < LOCKC + (k + 1) * GAP);
        return r;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_t    <= -1;
            m_lost <= 0;
            m_sync <= '0;
        end else begin
            m_t    <= next_t(m_t, m_sync[SYNC-1], soft_rst);
            m_lost <= next_lost(m_t, m_lost, m_sync[SYNC-1]);
            m_sync <= {m_sync[SYNC-2:0], locked};
        end
    end

    always @(negedge clock) begin
        check("model_rst_out", 32'(rst_out), 32'(exp_rst(m_t)));
        check("model_ready", 32'(ready), 32'(m_t >= T_RUN));
        check("model_lost", 32'(lost_count), 32'(m_lost));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        locked   = 1'b1;
        soft_rst = 1'b0;

        // Power-up: E is the second edge after reset_n release.
        tick(3);
        check("por_rst_out", 32'(rst_out), 32'h7);
        check("por_ready", 32'(ready), 32'h0);
        check("por_lost", 32'(lost_count), 32'h0);
        reset_n = 1'b1;
        tick(14);
        check("pu_e12_rst", 32'(rst_out), 32'h7);
        tick(1);
        check("pu_e13_rst", 32'(rst_out), 32'h6);
        tick(4);
        check("pu_e17_rst", 32'(rst_out), 32'h4);
        tick(3);
        check("pu_e20_ready", 32'(ready), 32'h0);
        tick(1);
        check("pu_e21_rst", 32'(rst_out), 32'h0);
        check("pu_e21_ready", 32'(ready), 32'h1);
        tick(2);

        // soft_rst in RUN, then a 3-cycle lock drop during SETTLE.
        soft_rst = 1'b1;
        tick(1);
        check("soft_run_rst", 32'(rst_out), 32'h7);
        check("soft_run_lost", 32'(lost_count), 32'h0);
        soft_rst = 1'b0;
        tick(5);
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        check("settle_drop_rst", 32'(rst_out), 32'h7);
        tick(14);
        check("settle_restart_pre", 32'(rst_out), 32'h7);
        tick(1);
        check("settle_restart_bit0", 32'(rst_out), 32'h6);
        tick(8);
        check("settle_restart_ready", 32'(ready), 32'h1);
        check("settle_lost", 32'(lost_count), 32'h0);

        // Lock drops in RUN; lost_count saturates at 3.
        for (int i = 0; i < 5; i++) begin
            locked = 1'b0;
            tick(2);
            check("run_drop_before", 32'(ready), 32'h1);
            tick(1);
            check("run_drop_rst", 32'(rst_out), 32'h7);
            check("run_drop_ready", 32'(ready), 32'h0);
            check("run_drop_lost", 32'(lost_count), 32'((i + 1 > 3) ? 3 : i + 1));
            locked = 1'b1;
            tick(24);
            check("run_relock_ready", 32'(ready), 32'h1);
        end

        // soft_rst pulse right after rst_out[0] falls in RELEASE.
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        tick(12);
        check("rel_pre_bit0", 32'(rst_out), 32'h7);
        tick(1);
        check("rel_bit0", 32'(rst_out), 32'h6);
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        check("rel_soft_rst", 32'(rst_out), 32'h7);
        tick(12);
        check("rel_again_pre", 32'(rst_out), 32'h7);
        tick(1);
        check("rel_again_bit0", 32'(rst_out), 32'h6);
        check("rel_soft_lost", 32'(lost_count), 32'h3);

        // locked_s reads 0 on the edge that would clear rst_out[2].
        tick(5);
        locked = 1'b0;
        tick(2);
        check("final_pre_rst", 32'(rst_out), 32'h4);
        tick(1);
        check("final_abort_rst", 32'(rst_out), 32'h7);
        check("final_abort_ready", 32'(ready), 32'h0);
        check("final_abort_lost", 32'(lost_count), 32'h3);

        // Asynchronous reset between edges while in RELEASE.
        locked = 1'b1;
        tick(15);
        check("async_pre_rst", 32'(rst_out), 32'h6);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", 32'(rst_out), 32'h7);
        check("async_ready", 32'(ready), 32'h0);
        check("async_lost", 32'(lost_count), 32'h0);
        #2;
        reset_n = 1'b1;
        tick(23);
        check("async_rerun_ready", 32'(ready), 32'h1);
        check("async_rerun_rst", 32'(rst_out), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
